joystick_led_sequencer: RTL
===========================

Name: joystick_led_sequencer

Overview:
Controller between the board's five active-low joystick keys (up/down/left/right/centre-z) and the 4-bit active-low LED bank. It synchronises and debounces each key, turns presses into single prioritised events, and drives the LEDs from a two-mode FSM: STATIC (direction-indicator patterns) or CHASE (a single lit LED rotating at a selectable speed). It sits directly between the key pins and the LED pins at board top level.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronised key level must differ from the debounced level before it is accepted (10 ms at 50 MHz); must be >= 2
STEP_CYCLES, 12500000, CHASE step period in clk cycles at speed level 0; must be a multiple of 8
CNT_W, 24, width of the debounce and step counters; must hold both DEBOUNCE_CYCLES-1 and STEP_CYCLES-1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
key_up  input  1  raw key, active-low, asynchronous to clk
key_down  input  1  raw key, active-low
key_left  input  1  raw key, active-low
key_right  input  1  raw key, active-low
key_z  input  1  raw centre key, active-low
led  output  4  LED drive, active-low (0 = lit)
mode  output  1  0 = STATIC, 1 = CHASE
speed  output  2  CHASE speed level 0..3
event_valid  output  1  one-cycle pulse per accepted press event
event_code  output  3  event code, valid while event_valid is high; 0 otherwise

Behaviour:
- Reset state: led=4'b1111, mode=0, speed=0, event_valid=0, event_code=0, direction=INC, step counter=0. Synchroniser and debounced levels reset to 1 (released); debounce counters reset to 0.
- Synchroniser: two flops per key.
- Debounce: the counter clears whenever the synchronised level equals the debounced level. The debounced level takes the new value once the two have differed for DEBOUNCE_CYCLES consecutive cycles, and the counter clears at that point.
- A press is a debounced 1->0 transition. Releases generate nothing.
- Latency: event_valid rises exactly DEBOUNCE_CYCLES+3 clk edges after the raw key falls and stays stable.
- Bounces shorter than DEBOUNCE_CYCLES produce no event.
- Event codes: up=1, down=2, left=3, right=4, z=5.
- Priority among presses detected in the same cycle: z > up > down > left > right. Only the winner is emitted; losers are discarded, not queued.
- A key held down emits exactly one event. There is no auto-repeat.
- The FSM acts in the same cycle that event_valid/event_code are registered. led, mode and speed change on the same edge that event_valid rises.
- STATIC state:
  - up -> led=1110
  - down -> led=0111
  - left -> led=1101
  - right -> led=1011
  - z -> enter CHASE: mode=1, led=1110, step counter=0, direction=INC.
- CHASE state:
  - Step period P = STEP_CYCLES >> speed.
  - The step counter counts 0..P-1. At P-1 it wraps to 0 and the lit LED moves one position.
  - INC rotation (lit index 0->1->2->3->0): 1110 -> 1101 -> 1011 -> 0111 -> 1110. DEC rotation is the reverse.
  - right -> direction=INC; left -> direction=DEC. The step counter is not cleared; the new direction applies at the next step.
  - up -> speed+1, saturating at 3. down -> speed-1, saturating at 0.
  - A speed event clears the step counter in the same cycle, even when the speed is saturated.
  - If a step boundary and an event coincide, the event wins: no rotation that cycle, and the counter follows the event rule above.
  - z -> return to STATIC: mode=0, led=1111, step counter=0.
- speed is retained across mode changes and cleared only by reset.
- Asynchronous reset asserted mid-debounce or mid-step returns every register to its reset value immediately; no event is emitted on release of reset.

Decomposition:
- Package joystick_pkg holds:
  - event code constants (EV_NONE=0 .. EV_Z=5)
  - mode encoding (MODE_STATIC, MODE_CHASE)
  - direction encoding (DIR_INC, DIR_DEC)
  - LED pattern constants (LED_OFF=1111, LED_UP=1110, LED_DOWN=0111, LED_LEFT=1101, LED_RIGHT=1011)
- Sub-module key_debounce: synchroniser, debounce counter and press-edge pulse for one key. It takes parameters DEBOUNCE_CYCLES and CNT_W and is instantiated five times.
- The top level holds the priority encoder, the FSM and the step counter.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, STEP_CYCLES=16.)
1. Reset, no keys pressed -> led=1111, mode=0, speed=0, and event_valid never pulses.
2. key_up low for 20 cycles, then high -> one event_valid pulse 7 edges after the fall with event_code=1, led=1110. No event on release.
3. key_left toggling every 2 cycles for 30 cycles, then held low -> no event during toggling, then exactly one event with code 3, led=1101.
4. key_up and key_z falling on the same edge -> single event with code 5, mode=1, led=1110. Then every 16 cycles led steps 1101, 1011, 0111, 1110.
5. In CHASE: press up three times, then once more -> speed 1, 2, 3, 3, and the step period becomes 2 cycles. Press left -> the next step moves led 1110 -> 0111.
6. In CHASE: press z -> mode=0, led=1111, speed stays 3. Assert reset mid-debounce of key_down -> all outputs return to reset values and no event follows.

Source files
------------

// File: rtl/joystick_pkg.sv
// Shared encodings for the joystick/LED sequencer: event codes, modes,
// rotation direction and the active-low LED patterns.
package joystick_pkg;

  localparam logic [2:0] EV_NONE  = 3'd0;
  localparam logic [2:0] EV_UP    = 3'd1;
  localparam logic [2:0] EV_DOWN  = 3'd2;
  localparam logic [2:0] EV_LEFT  = 3'd3;
  localparam logic [2:0] EV_RIGHT = 3'd4;
  localparam logic [2:0] EV_Z     = 3'd5;

  typedef enum logic {MODE_STATIC = 1'b0, MODE_CHASE = 1'b1} mode_e;
  typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_e;

  localparam logic [3:0] LED_OFF   = 4'b1111;
  localparam logic [3:0] LED_UP    = 4'b1110;
  localparam logic [3:0] LED_DOWN  = 4'b0111;
  localparam logic [3:0] LED_LEFT  = 4'b1101;
  localparam logic [3:0] LED_RIGHT = 4'b1011;

  typedef struct packed {
    logic       valid;
    logic [2:0] code;
  } ev_t;

  // Active-low single-lit pattern: INC moves the zero towards the MSB.
  function automatic logic [3:0] rotate_led(input logic [3:0] l, input dir_e d);
    return (d == DIR_INC) ? {l[2:0], l[3]} : {l[0], l[3:1]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser, consecutive-cycle debounce and a
// registered single-cycle pulse on an accepted press (1->0).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             deb_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;
  logic             key_s;
  logic             accept;

  assign key_s   = sync_q[1];
  assign accept  = (key_s != deb_q) && (cnt_q == DEB_LAST);
  assign press_o = press_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      press_q <= accept && !key_s;
      if (key_s == deb_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        deb_q <= key_s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/joystick_led_sequencer.sv
// Five debounced joystick keys -> prioritised press events -> STATIC/CHASE
// LED FSM with a speed-scaled step counter.
module joystick_led_sequencer
  import joystick_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int STEP_CYCLES     = 12500000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_z,
  output logic [3:0] led,
  output logic       mode,
  output logic [1:0] speed,
  output logic       event_valid,
  output logic [2:0] event_code
);

  localparam int               NUM_KEYS = 5;
  localparam logic [CNT_W-1:0] STEP_P   = CNT_W'(STEP_CYCLES);

  logic [NUM_KEYS-1:0] keys_n;
  logic [NUM_KEYS-1:0] press;
  ev_t                 ev_d, ev_q;
  mode_e               mode_q;
  dir_e                dir_q;
  logic [3:0]          led_q;
  logic [1:0]          speed_q;
  logic [CNT_W-1:0]    step_q;
  logic [CNT_W-1:0]    period;
  logic                step_last;

  assign keys_n = {key_z, key_right, key_left, key_down, key_up};

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key (
      .clk    (clk),
      .reset  (reset),
      .key_n_i(keys_n[gi]),
      .press_o(press[gi])
    );
  end

  // Simultaneous presses: z > up > down > left > right, losers dropped.
  always_comb begin
    ev_d = '0;
    if      (press[4]) ev_d.code = EV_Z;
    else if (press[0]) ev_d.code = EV_UP;
    else if (press[1]) ev_d.code = EV_DOWN;
    else if (press[2]) ev_d.code = EV_LEFT;
    else if (press[3]) ev_d.code = EV_RIGHT;
    ev_d.valid = (ev_d.code != EV_NONE);
  end

  assign period    = STEP_P >> speed_q;
  assign step_last = (step_q == period - 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_q    <= '0;
      mode_q  <= MODE_STATIC;
      dir_q   <= DIR_INC;
      led_q   <= LED_OFF;
      speed_q <= 2'd0;
      step_q  <= '0;
    end else begin
      ev_q <= ev_d;
      case (mode_q)
        MODE_STATIC: begin
          step_q <= '0;
          case (ev_d.code)
            EV_UP:    led_q <= LED_UP;
            EV_DOWN:  led_q <= LED_DOWN;
            EV_LEFT:  led_q <= LED_LEFT;
            EV_RIGHT: led_q <= LED_RIGHT;
            EV_Z: begin
              mode_q <= MODE_CHASE;
              led_q  <= LED_UP;
              dir_q  <= DIR_INC;
            end
            default: ;
          endcase
        end
        default: begin
          step_q <= step_last ? '0 : step_q + 1'b1;
          // An event in the boundary cycle suppresses that rotation.
          if (!ev_d.valid && step_last) led_q <= rotate_led(led_q, dir_q);
          case (ev_d.code)
            EV_UP: begin
              if (speed_q != 2'd3) speed_q <= speed_q + 2'd1;
              step_q <= '0;
            end
            EV_DOWN: begin
              if (speed_q != 2'd0) speed_q <= speed_q - 2'd1;
              step_q <= '0;
            end
            EV_LEFT:  dir_q <= DIR_DEC;
            EV_RIGHT: dir_q <= DIR_INC;
            EV_Z: begin
              mode_q <= MODE_STATIC;
              led_q  <= LED_OFF;
              step_q <= '0;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign led         = led_q;
  assign mode        = mode_q;
  assign speed       = speed_q;
  assign event_valid = ev_q.valid;
  assign event_code  = ev_q.code;

endmodule
